// File: rtl/mux2a1_l2_if.sv
// rtl/mux2a1_l2_if.sv - lane inputs and serialized stream outputs of the 2:1 L2 serializer
interface mux2a1_l2_if #(
   parameter int WIDTH = 8
);
   logic             valid0;
   logic [WIDTH-1:0] data_in0;
   logic             valid1;
   logic [WIDTH-1:0] data_in1;
   logic             phase_out;
   logic             valid_out;
   logic [WIDTH-1:0] data_out;
   logic             lane_out;
   logic [7:0]       word_count;
   logic             overrun;

   modport master (
      output valid0, data_in0, valid1, data_in1,
      input  phase_out, valid_out, data_out, lane_out, word_count, overrun
   );

   modport slave (
      input  valid0, data_in0, valid1, data_in1,
      output phase_out, valid_out, data_out, lane_out, word_count, overrun
   );
endinterface

// File: rtl/mux2a1_l2.sv
// rtl/mux2a1_l2.sv - 2:1 serializer: captures two lanes on phase 0, emits lane0 then lane1
module mux2a1_l2 #(
   parameter int WIDTH = 8
) (
   input  logic        clk_4f,
   input  logic        reset_L,
   mux2a1_l2_if.slave  bus
);
   logic             phase_q, phase_d;
   logic [WIDTH-1:0] hold0_q, hold0_d;
   logic [WIDTH-1:0] hold1_q, hold1_d;
   logic             hv0_q, hv0_d;
   logic             hv1_q, hv1_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             valid_out_q, valid_out_d;
   logic             lane_out_q, lane_out_d;
   logic [7:0]       word_count_q, word_count_d;
   logic             overrun_q, overrun_d;

   logic [WIDTH-1:0] slot_data;
   logic             slot_valid;

   always_comb begin
      phase_d      = ~phase_q;
      hold0_d      = hold0_q;
      hold1_d      = hold1_q;
      hv0_d        = hv0_q;
      hv1_d        = hv1_q;
      overrun_d    = overrun_q;
      data_out_d   = data_out_q;
      word_count_d = word_count_q;
      slot_data    = hold0_q;
      slot_valid   = hv0_q;
      lane_out_d   = 1'b0;
      if (!phase_q) begin
         // Slot reads the old hold1 before it is overwritten: no bypass path.
         slot_data  = hold1_q;
         slot_valid = hv1_q;
         lane_out_d = 1'b1;
         hold0_d    = bus.data_in0;
         hv0_d      = bus.valid0;
         hold1_d    = bus.data_in1;
         hv1_d      = bus.valid1;
      end else if (bus.valid0 || bus.valid1) begin
         overrun_d = 1'b1;
      end
      valid_out_d = slot_valid;
      if (slot_valid) begin
         data_out_d   = slot_data;
         word_count_d = word_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk_4f) begin
      if (!reset_L) begin
         phase_q      <= 1'b0;
         hold0_q      <= '0;
         hold1_q      <= '0;
         hv0_q        <= 1'b0;
         hv1_q        <= 1'b0;
         data_out_q   <= '0;
         valid_out_q  <= 1'b0;
         lane_out_q   <= 1'b0;
         word_count_q <= 8'd0;
         overrun_q    <= 1'b0;
      end else begin
         phase_q      <= phase_d;
         hold0_q      <= hold0_d;
         hold1_q      <= hold1_d;
         hv0_q        <= hv0_d;
         hv1_q        <= hv1_d;
         data_out_q   <= data_out_d;
         valid_out_q  <= valid_out_d;
         lane_out_q   <= lane_out_d;
         word_count_q <= word_count_d;
         overrun_q    <= overrun_d;
      end
   end

   assign bus.phase_out  = phase_q;
   assign bus.valid_out  = valid_out_q;
   assign bus.data_out   = data_out_q;
   assign bus.lane_out   = lane_out_q;
   assign bus.word_count = word_count_q;
   assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_mux2a1_l2.sv
// tb/tb_mux2a1_l2.sv - scoreboard bench for mux2a1_l2
module tb_mux2a1_l2;
   logic clk_4f;
   logic reset_L;
   int   n_total;
   int   n_bad;
   logic [7:0] exp_wc;
   logic [8:0] sb_q[$];

   mux2a1_l2_if #(.WIDTH(8)) bus ();

   mux2a1_l2 #(.WIDTH(8)) dut (
      .clk_4f  (clk_4f),
      .reset_L (reset_L),
      .bus     (bus)
   );

   initial clk_4f = 1'b0;
   always #5 clk_4f = ~clk_4f;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every valid output word must match the head of the scoreboard.
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk_4f);
         if (bus.valid_out === 1'b1) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_word", {bus.lane_out, bus.data_out}, 9'h1ff);
            end else begin
               e = sb_q.pop_front();
               chk("stream_data", bus.data_out, e[7:0]);
               chk("stream_lane", bus.lane_out, e[8]);
            end
         end
      end
   end

   task automatic capture(input logic v0, input logic [7:0] d0,
                          input logic v1, input logic [7:0] d1, input bit push);
      int guard;
      guard = 0;
      @(negedge clk_4f);
      while (bus.phase_out !== 1'b0 && guard < 4) begin
         @(negedge clk_4f);
         guard++;
      end
      if (guard >= 4) chk("phase0_timeout", guard, 0);
      bus.valid0   = v0;
      bus.data_in0 = d0;
      bus.valid1   = v1;
      bus.data_in1 = d1;
      if (push) begin
         if (v0) begin sb_q.push_back({1'b0, d0}); exp_wc++; end
         if (v1) begin sb_q.push_back({1'b1, d1}); exp_wc++; end
      end
      @(posedge clk_4f);
      #1;
      bus.valid0 = 1'b0;
      bus.valid1 = 1'b0;
   endtask

   task automatic step();
      @(posedge clk_4f);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_phase"}, bus.phase_out, 0);
      chk({tag, "_valid"}, bus.valid_out, 0);
      chk({tag, "_data"}, bus.data_out, 0);
      chk({tag, "_lane"}, bus.lane_out, 0);
      chk({tag, "_wc"}, bus.word_count, 0);
      chk({tag, "_overrun"}, bus.overrun, 0);
   endtask

   initial begin
      n_total      = 0;
      n_bad        = 0;
      exp_wc       = 8'd0;
      reset_L      = 1'b0;
      bus.valid0   = 1'b0;
      bus.valid1   = 1'b0;
      bus.data_in0 = 8'h00;
      bus.data_in1 = 8'h00;
      step();
      step();
      chk_all_zero("reset");

      // Release reset; first high edge captures (0x10,0x12).
      @(negedge clk_4f);
      reset_L = 1'b1;
      capture(1'b1, 8'h10, 1'b1, 8'h12, 1'b1);
      chk("release_valid", bus.valid_out, 0);
      step();
      chk("lane0_data", bus.data_out, 8'h10);
      chk("lane0_lane", bus.lane_out, 0);
      step();
      chk("lane1_data", bus.data_out, 8'h12);
      chk("lane1_lane", bus.lane_out, 1);
      chk("wc_two", bus.word_count, 2);

      // Lane 0 invalid: data_out holds 0x12.
      capture(1'b0, 8'h55, 1'b1, 8'h0A, 1'b1);
      step();
      chk("inv_slot_valid", bus.valid_out, 0);
      chk("inv_slot_hold", bus.data_out, 8'h12);
      chk("inv_slot_lane", bus.lane_out, 0);
      chk("inv_slot_wc", bus.word_count, 2);
      step();
      chk("lane1_0a", bus.data_out, 8'h0A);

      // Back-to-back captures stream continuously.
      capture(1'b1, 8'h01, 1'b1, 8'h02, 1'b1);
      capture(1'b1, 8'h03, 1'b1, 8'h04, 1'b1);
      chk("b2b_valid_2", bus.valid_out, 1);
      chk("b2b_data_2", bus.data_out, 8'h02);
      step();
      chk("b2b_valid_3", bus.valid_out, 1);
      step();
      chk("b2b_valid_4", bus.valid_out, 1);
      chk("b2b_data_4", bus.data_out, 8'h04);
      chk("b2b_wc", bus.word_count, exp_wc);
      chk("no_overrun_yet", bus.overrun, 0);

      // Drive a lane during phase 1: overrun, word dropped.
      @(negedge clk_4f);
      if (bus.phase_out !== 1'b1) @(negedge clk_4f);
      bus.valid0   = 1'b1;
      bus.data_in0 = 8'h77;
      step();
      bus.valid0 = 1'b0;
      chk("overrun_set", bus.overrun, 1);
      step();
      step();
      chk("overrun_sticky", bus.overrun, 1);
      capture(1'b1, 8'h21, 1'b1, 8'h22, 1'b1);
      step();
      step();
      chk("overrun_wc", bus.word_count, exp_wc);
      chk("overrun_still", bus.overrun, 1);

      // Reset one edge after capturing: held words discarded.
      capture(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0);
      reset_L = 1'b0;
      step();
      chk_all_zero("midreset");
      step();
      @(negedge clk_4f);
      reset_L = 1'b1;
      exp_wc  = 8'd0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_reset_valid", bus.valid_out, 0);
      end
      chk("post_reset_wc", bus.word_count, 0);

      // 257 words: counter wraps to 1.
      for (int i = 0; i < 128; i++) begin
         capture(1'b1, 8'(2 * i), 1'b1, 8'(2 * i + 1), 1'b1);
      end
      capture(1'b1, 8'hE5, 1'b0, 8'h00, 1'b1);
      step();
      step();
      step();
      chk("wrap_wc", bus.word_count, 1);
      chk("wrap_model", bus.word_count, exp_wc);
      chk("sb_drained", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/mux2a1_l2.md
MUX2A1_L2 -- requirements
Module: mux2a1_L2

Interface
REQ-001 Parameter WIDTH, default 8, lane and output data width in bits.
REQ-002 clk_4f  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset_L  input  1  reset, synchronous, active-low; sampled on rising clk_4f.
REQ-004 valid0  input  1  lane-0 word present.
REQ-005 data_in0  input  WIDTH  lane-0 word.
REQ-006 valid1  input  1  lane-1 word present.
REQ-007 data_in1  input  WIDTH  lane-1 word.
REQ-008 phase_out  output  1  internal phase bit; 0 = capture cycle, upstream drives lanes only when 0.
REQ-009 valid_out  output  1  data_out carries a valid word this cycle.
REQ-010 data_out  output  WIDTH  serialized word.
REQ-011 lane_out  output  1  source lane of the current data_out (0/1).
REQ-012 word_count  output  8  number of valid words emitted, mod 256.
REQ-013 overrun  output  1  sticky error flag.

Function
REQ-014 The block SHALL be the 2:1 serializer pairing the 1:2 L2 demux: two lanes in, one stream out at clk_4f.
REQ-015 phase SHALL toggle on every rising edge with reset_L high; all outputs SHALL be registered.
REQ-016 Edge with phase=0: hold0/hv0 <= data_in0/valid0, hold1/hv1 <= data_in1/valid1 (invalid lanes still captured, hv=0).
REQ-017 Same phase=0 edge: output slot = previous hold1/hv1, lane_out<=1.
REQ-018 Edge with phase=1: output slot = hold0/hv0, lane_out<=0; hold registers unchanged.
REQ-019 Output slot with hv=1: data_out<=hold, valid_out<=1, word_count<=word_count+1 (8-bit wrap 255->0).
REQ-020 Output slot with hv=0: valid_out<=0, data_out and word_count SHALL hold previous value; lane_out still updates.
REQ-021 Latency: lane-0 word on data_out 2 edges after presentation, lane-1 word 3 edges after; order always lane0 then lane1.
REQ-022 Reading hold1 and overwriting it on the same phase=0 edge SHALL emit the old value (no bypass).
REQ-023 valid0 or valid1 high during phase=1: inputs ignored, overrun<=1; overrun SHALL stay 1 until reset.
REQ-024 Overrun SHALL NOT stall or alter the data path.
REQ-025 No backpressure: every captured valid word SHALL be emitted exactly once.

Reset
REQ-026 reset_L=0 at an edge: phase, hold0, hold1, hv0, hv1, data_out, valid_out, lane_out, word_count, overrun SHALL all be 0.
REQ-027 Reset mid-operation SHALL discard any held word; the first edge with reset_L high is a phase=0 capture edge.
REQ-028 Output during and one edge after reset release: valid_out=0 (hold1 empty).

Verification
REQ-029 Reset 2 edges, then phase 0: valid0=1 data_in0=0x10, valid1=1 data_in1=0x12 -> edge+2: data_out=0x10 lane_out=0 valid_out=1; edge+3: 0x12 lane_out=1; word_count=2.
REQ-030 Phase 0: valid0=0, valid1=1 data_in1=0x0A -> lane-0 slot valid_out=0, data_out holds prior value; lane-1 slot 0x0A valid_out=1.
REQ-031 Back-to-back capture cycles with pairs (0x01,0x02),(0x03,0x04) -> stream 0x01,0x02,0x03,0x04 on consecutive edges, valid_out continuously 1.
REQ-032 valid0=1 during phase=1 -> overrun=1 next edge and stays 1, word not emitted, subsequent phase-0 traffic unaffected.
REQ-033 Emit 257 valid words -> word_count=1 (wrap).
REQ-034 Assert reset_L=0 one edge after capturing (0xAA,0xBB) -> neither word emitted, all outputs 0, overrun cleared.
